mux_nx1_stream: RTL
===================

MUX_NX1_STREAM -- requirements
Module: mux_nx1_stream

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, width of each data channel.
REQ-002 Parameter: NUM_IN, default 4, number of input channels, legal range 2..16.
REQ-003 Localparam: SEL_WIDTH = $clog2(NUM_IN), channel index width.
REQ-004 CLK  input  1  single clock, rising-edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 select  input  SEL_WIDTH  channel to forward in fixed-select mode.
REQ-007 in_data  input  NUM_IN*DATA_WIDTH  flattened inputs; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 in_valid  input  NUM_IN  per-channel valid.
REQ-009 in_ready  output  NUM_IN  per-channel ready.
REQ-010 out_data  output  DATA_WIDTH  registered selected data.
REQ-011 out_valid  output  1  out_data holds a word.
REQ-012 out_ready  input  1  downstream accepts a word.
REQ-013 out_chan  output  SEL_WIDTH  source channel index of out_data.

Function
REQ-014 The block SHALL contain one output register stage (out_data, out_chan, out_valid); latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-015 Stage "free" SHALL be defined as (!out_valid || out_ready).
REQ-016 Exactly one channel g (the grant) or none SHALL be chosen per cycle; in_ready[i] SHALL be 1 only when i == g and the stage is free; all other in_ready bits SHALL be 0.
REQ-017 An input transfer SHALL occur when in_valid[g] && in_ready[g]; on it out_data <= channel g data, out_chan <= g, out_valid <= 1.
REQ-018 An output transfer (out_valid && out_ready) with no simultaneous input transfer SHALL clear out_valid; simultaneous output and input transfers SHALL reload the stage with no bubble (full throughput, one word/cycle).
REQ-019 While out_valid && !out_ready, out_data and out_chan SHALL stay stable and all in_ready SHALL be 0.
REQ-020 Fixed-select mode: g = select, evaluated combinationally each cycle; select changes take effect the same cycle; in_ready[g] SHALL not depend on in_valid[g].
REQ-021 select >= NUM_IN (non-power-of-2 NUM_IN) SHALL produce no grant: all in_ready 0, no transfer.
REQ-022 out_data SHALL retain its last value when out_valid is 0.

Reset
REQ-023 On RST low, asynchronously: out_valid = 0, out_data = 0, out_chan = 0, round-robin pointer = NUM_IN-1; in_ready SHALL be all 0 while RST is low.
REQ-024 Reset asserted mid-transfer SHALL discard the held word; no transfer SHALL be reported in the reset cycle.

Configuration
REQ-025 Macro MUX_NX1_STREAM_RR_EN: when defined, select SHALL be ignored and g SHALL be the first channel with in_valid set, searching cyclically from (pointer+1) mod NUM_IN; pointer SHALL update to g only on an input transfer; no valid input means no grant.
REQ-026 With RR enabled, a channel kept valid SHALL be granted within NUM_IN input transfers (starvation-free).
REQ-027 Without MUX_NX1_STREAM_RR_EN: fixed-select mode per REQ-020; pointer logic SHALL not be synthesised.

Structure
REQ-028 Package mux_pkg SHALL hold the default DATA_WIDTH and NUM_IN constants and a channel-index width function.
REQ-029 Round-robin search SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot/index grant), instantiated only under the macro.

Verification
REQ-030 Fixed mode, NUM_IN=4: select=2, in_valid=4'b0100, in_data ch2=16'hA5A5, out_ready=1 -> next cycle out_data=16'hA5A5, out_chan=2, out_valid=1; in_ready=4'b0100.
REQ-031 Backpressure: out_ready=0 with word held for 3 cycles -> out_data/out_chan stable, in_ready=0; out_ready=1 with new ch2 word -> same-cycle reload, no bubble.
REQ-032 NUM_IN=3, select=3 -> in_ready=3'b000, out_valid stays 0 for 5 cycles.
REQ-033 RR enabled, all 4 valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
REQ-034 RR enabled, in_valid=4'b1010 -> grants alternate 1,3,1,3; pointer unchanged while no transfer.
REQ-035 RST low while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0 immediately; after release, first RR grant is channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the N:1 stream multiplexer.
//   DEF_DATA_WIDTH : default channel data width
//   DEF_NUM_IN     : default channel count
//   chan_w()       : channel-index width for a given channel count
package mux_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_NUM_IN     = 4;

  // Index width for n channels; never returns 0 so ports stay legal.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// Round-robin search for the stream mux (built only with MUX_NX1_STREAM_RR_EN).
// Ports:
//   i_req         : per-channel request (in_valid)
//   i_ptr         : last granted channel; the search starts at i_ptr+1
//   o_grant_oh_c  : one-hot grant, combinational
//   o_grant_idx_c : grant index, combinational
//   o_grant_vld_c : any request found, combinational
`ifdef MUX_NX1_STREAM_RR_EN
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_IN    = DEF_NUM_IN,
  parameter int unsigned SEL_WIDTH = chan_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0]    i_req,
  input  logic [SEL_WIDTH-1:0] i_ptr,
  output logic [NUM_IN-1:0]    o_grant_oh_c,
  output logic [SEL_WIDTH-1:0] o_grant_idx_c,
  output logic                 o_grant_vld_c
);

  // Cyclic first-set search starting one past the pointer.
  always_comb begin
    int unsigned w_cand;
    o_grant_oh_c  = '0;
    o_grant_idx_c = '0;
    o_grant_vld_c = 1'b0;
    w_cand        = 0;
    for (int unsigned off = 1; off <= NUM_IN; off++) begin
      w_cand = (32'(i_ptr) + off) % NUM_IN;
      for (int unsigned j = 0; j < NUM_IN; j++) begin
        if (!o_grant_vld_c && (j == w_cand) && i_req[j]) begin
          o_grant_oh_c[j] = 1'b1;
          o_grant_idx_c   = SEL_WIDTH'(j);
          o_grant_vld_c   = 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/mux_nx1_stream.sv
// N:1 valid/ready stream multiplexer with a single registered output stage.
// Build option: define MUX_NX1_STREAM_RR_EN for round-robin arbitration
// (select is then ignored); otherwise select fixes the granted channel.
// Ports:
//   CLK, RST   : clock (rising edge), async active-low reset
//   select     : channel to forward in fixed-select mode
//   in_data    : flattened inputs, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (combinational, at most one bit set)
//   out_data   : registered selected data
//   out_valid  : out_data holds a word
//   out_ready  : downstream accepts a word
//   out_chan   : source channel of out_data
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_IN     = DEF_NUM_IN,
  localparam int unsigned SEL_WIDTH = chan_w(NUM_IN)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [SEL_WIDTH-1:0]         select,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_WIDTH-1:0]         out_chan
);

  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SEL_WIDTH-1:0]  r_out_chan;
  logic                  r_out_valid;

  logic [NUM_IN-1:0]     w_grant_oh;
  logic [SEL_WIDTH-1:0]  w_grant_idx;
  logic                  w_free;
  logic                  w_in_xfer;
  logic [DATA_WIDTH-1:0] w_sel_data;

  assign w_free = !r_out_valid || out_ready;

`ifdef MUX_NX1_STREAM_RR_EN
  logic [SEL_WIDTH-1:0] r_rr_ptr;
  logic                 w_grant_vld;

  rr_arbiter #(
    .NUM_IN    (NUM_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_arbiter (
    .i_req         (in_valid),
    .i_ptr         (r_rr_ptr),
    .o_grant_oh_c  (w_grant_oh),
    .o_grant_idx_c (w_grant_idx),
    .o_grant_vld_c (w_grant_vld)
  );

  // Pointer advances only when a word is actually taken.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rr_ptr <= SEL_WIDTH'(NUM_IN - 1);
    end else if (w_in_xfer && w_grant_vld) begin
      r_rr_ptr <= w_grant_idx;
    end
  end
`else
  // Fixed select: out-of-range select decodes to no grant.
  always_comb begin
    w_grant_oh = '0;
    for (int unsigned j = 0; j < NUM_IN; j++) begin
      w_grant_oh[j] = (select == SEL_WIDTH'(j));
    end
  end
  assign w_grant_idx = select;
`endif

  // Ready goes only to the grant, never while held or in reset.
  assign in_ready  = (RST && w_free) ? w_grant_oh : '0;
  assign w_in_xfer = |(in_ready & in_valid);

  // Data steering from the one-hot grant avoids out-of-range slices.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned j = 0; j < NUM_IN; j++) begin
      if (w_grant_oh[j]) begin
        w_sel_data = in_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output stage: reload on input transfer, drain on output-only transfer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_chan  <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;

endmodule
